rf_wb_arbiter: RTL and testbench

Shares the register file's single write port (WE3/A3/WD3) between two writeback sources.
- Port P: the in-order pipeline WB stage.
- Port M: a long-latency unit (divider/load miss) that completes out of band.
- M results sit in a small FIFO. P has fixed priority, with a starvation guard for M.
- A registered write command drives the register file. A pending-write mask feeds the hazard unit.

---
 rtl/rf_wb_arbiter_pkg.sv | 12 +
 rtl/rf_wb_fifo.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 76 +++++++
 tb/tb_rf_wb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared writeback constants, request struct and one-hot helper for pend_mask
package rf_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int RW = 5;
  typedef struct packed {
    logic [RW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
  function automatic logic [31:0] onehot32(input logic [RW-1:0] r);
    return 32'(1) << r;
  endfunction
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: sync FIFO of {rd,data} (push/pop in, head/count out) exposing per-entry rd + valid for pend_mask
module rf_wb_fifo import rf_wb_arbiter_pkg::RW; #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [RW-1:0] din_rd,
  input  logic [W-1:0] din_data,
  output logic [RW-1:0] head_rd,
  output logic [W-1:0] head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0][RW-1:0] rds,
  output logic [DEPTH-1:0] vld
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wptr, rptr;
  logic [DEPTH-1:0][W-1:0] mem;
  assign head_rd = rds[rptr];
  assign head_data = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        rds[wptr] <= din_rd;
        mem[wptr] <= din_data;
        vld[wptr] <= 1'b1;
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between pipeline WB (p_*) and buffered long-latency results (m_*), driving rf_we/rf_a3/rf_wd and pend_mask
module rf_wb_arbiter import rf_wb_arbiter_pkg::RW; #(
  parameter int XLEN = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic p_valid,
  input  logic [RW-1:0] p_rd,
  input  logic [XLEN-1:0] p_data,
  output logic p_ready,
  input  logic m_valid,
  input  logic [RW-1:0] m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic m_ready,
  output logic rf_we,
  output logic [RW-1:0] rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0] pend_mask
);
  import rf_wb_arbiter_pkg::onehot32;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] count;
  logic [RW-1:0] head_rd;
  logic [XLEN-1:0] head_data;
  logic [FIFO_DEPTH-1:0][RW-1:0] rds;
  logic [FIFO_DEPTH-1:0] vld;
  logic [SW-1:0] starve_cnt;
  logic fc, force_f, pc, gnt_p, gnt_f, push;
  always_comb begin
    fc = count != '0;
    force_f = fc && starve_cnt == SW'(STARVE_LIMIT);
    pc = p_valid && p_rd != '0;
    gnt_p = pc && !force_f;
    gnt_f = fc && !gnt_p;
    p_ready = !rst && !force_f;
    m_ready = !rst && count != CW'(FIFO_DEPTH);
    push = m_valid && m_ready && m_rd != '0;
  end
  always_comb begin
    pend_mask = rf_we ? onehot32(rf_a3) : '0;
    for (int i = 0; i < FIFO_DEPTH; i++) pend_mask |= vld[i] ? onehot32(rds[i]) : '0;
    pend_mask[0] = 1'b0;
  end
  // a lost cycle implies !force_f, so starve_cnt is below the limit and cannot overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rf_we <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= gnt_p || gnt_f;
      if (gnt_p || gnt_f) begin
        rf_a3 <= gnt_p ? p_rd : head_rd;
        rf_wd <= gnt_p ? p_data : head_data;
      end
      starve_cnt <= (gnt_f || !fc) ? '0 : starve_cnt + 1'b1;
    end
  end
  rf_wb_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(gnt_f),
    .din_rd(m_rd),
    .din_data(m_data),
    .head_rd(head_rd),
    .head_data(head_data),
    .count(count),
    .rds(rds),
    .vld(vld)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table, hand sequences and random traffic against a queue-based model
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;
  localparam int D = 2;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst, p_valid, m_valid, p_ready, m_ready, rf_we;
  logic [4:0] p_rd, m_rd, rf_a3;
  logic [31:0] p_data, m_data, rf_wd, pend_mask;
  always #5 clk = ~clk;
  rf_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(D), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pend_mask(pend_mask)
  );
  int n_cmp = 0;
  int n_bad = 0;
  wb_req_t q[$];
  int st;
  logic mwe;
  logic [4:0] ma3;
  logic [31:0] mwd;
  typedef struct {
    logic pv;
    logic [4:0] prd;
    logic [31:0] pd;
    logic mv;
    logic [4:0] mrd;
    logic [31:0] md;
    logic pr, mr, we;
    logic [4:0] a3;
    logic [31:0] wd, pm;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(int pv, int prd, int pd, int mv, int mrd, int md,
                              int pr, int mr, int we, int a3, int wd, int pm);
    vec_t v;
    v.pv = 1'(pv); v.prd = 5'(prd); v.pd = 32'(pd);
    v.mv = 1'(mv); v.mrd = 5'(mrd); v.md = 32'(md);
    v.pr = 1'(pr); v.mr = 1'(mr); v.we = 1'(we);
    v.a3 = 5'(a3); v.wd = 32'(wd); v.pm = 32'(pm);
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    rst = r; p_valid = pv; p_rd = prd; p_data = pd;
    m_valid = mv; m_rd = mrd; m_data = md;
    #1;
  endtask
  // Model: P writes when it has a real request and M is not overdue; otherwise the oldest M result writes.
  task automatic tick();
    bit fc, frc, gp, gf, acc;
    fc = q.size() != 0;
    frc = fc && st == SL;
    gp = p_valid && p_rd != 0 && !frc;
    gf = fc && !gp;
    acc = q.size() < D;
    @(posedge clk);
    if (rst) begin
      q.delete(); st = 0; mwe = 0; ma3 = 0; mwd = 0;
    end else begin
      mwe = gp || gf;
      if (gp) begin
        ma3 = p_rd; mwd = p_data;
      end else if (gf) begin
        ma3 = q[0].rd; mwd = q[0].data;
        void'(q.pop_front());
      end
      if (m_valid && acc && m_rd != 0) q.push_back('{rd: m_rd, data: m_data});
      st = (gf || !fc) ? 0 : (st < SL ? st + 1 : SL);
    end
    @(negedge clk);
  endtask
  task automatic check_model(input int c);
    logic [31:0] pm;
    bit frc;
    frc = q.size() != 0 && st == SL;
    pm = mwe ? 32'(1) << ma3 : 32'(0);
    foreach (q[k]) pm |= 32'(1) << q[k].rd;
    chk($sformatf("rnd%0d p_ready", c), 32'(p_ready), 32'(!rst && !frc));
    chk($sformatf("rnd%0d m_ready", c), 32'(m_ready), 32'(!rst && q.size() < D));
    chk($sformatf("rnd%0d rf_we", c), 32'(rf_we), 32'(mwe));
    chk($sformatf("rnd%0d rf_a3", c), 32'(rf_a3), 32'(ma3));
    chk($sformatf("rnd%0d rf_wd", c), rf_wd, mwd);
    chk($sformatf("rnd%0d pend_mask", c), pend_mask, pm);
  endtask
  initial begin
    // pv,prd,pd, mv,mrd,md | p_ready,m_ready,rf_we,rf_a3,rf_wd,pend_mask
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,0,0,0,0));
    tv.push_back(mk(1,5,'hDEADBEEF, 0,0,0,      1,1,0,0,0,0));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,5,'hDEADBEEF,1<<5));
    tv.push_back(mk(1,0,'h1234,     1,0,'h5678, 1,1,0,5,'hDEADBEEF,0));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,0,5,'hDEADBEEF,0));
    tv.push_back(mk(0,0,0,          1,7,'h11,   1,1,0,5,'hDEADBEEF,0));
    tv.push_back(mk(0,0,0,          1,9,'h22,   1,1,0,5,'hDEADBEEF,1<<7));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,7,'h11,(1<<7)|(1<<9)));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,9,'h22,1<<9));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,0,9,'h22,0));
    tv.push_back(mk(1,3,'hA0,       1,10,'hA,   1,1,0,9,'h22,0));
    tv.push_back(mk(1,3,'hA1,       1,11,'hB,   1,1,1,3,'hA0,(1<<3)|(1<<10)));
    tv.push_back(mk(1,3,'hA2,       1,12,'hC,   1,0,1,3,'hA1,(1<<3)|(1<<10)|(1<<11)));
    tv.push_back(mk(1,3,'hA3,       1,12,'hC,   1,0,1,3,'hA2,(1<<3)|(1<<10)|(1<<11)));
    tv.push_back(mk(1,3,'hA4,       1,12,'hC,   1,0,1,3,'hA3,(1<<3)|(1<<10)|(1<<11)));
    tv.push_back(mk(1,3,'hA5,       1,12,'hC,   0,0,1,3,'hA4,(1<<3)|(1<<10)|(1<<11)));
    tv.push_back(mk(1,3,'hA5,       1,12,'hC,   1,1,1,10,'hA,(1<<10)|(1<<11)));
    tv.push_back(mk(0,0,0,          0,0,0,      1,0,1,3,'hA5,(1<<3)|(1<<11)|(1<<12)));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,11,'hB,(1<<11)|(1<<12)));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,12,'hC,1<<12));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,0,12,'hC,0));
    tv.push_back(mk(0,0,0,          1,4,'h44,   1,1,0,12,'hC,0));
    tv.push_back(mk(1,4,'h40,       0,0,0,      1,1,0,12,'hC,1<<4));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,4,'h40,1<<4));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,1,4,'h44,1<<4));
    tv.push_back(mk(0,0,0,          0,0,0,      1,1,0,4,'h44,0));
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("reset p_ready", 32'(p_ready), 0);
    chk("reset m_ready", 32'(m_ready), 0);
    tick();
    for (int i = 0; i < tv.size(); i++) begin
      drive(0, tv[i].pv, tv[i].prd, tv[i].pd, tv[i].mv, tv[i].mrd, tv[i].md);
      chk($sformatf("v%0d p_ready", i), 32'(p_ready), 32'(tv[i].pr));
      chk($sformatf("v%0d m_ready", i), 32'(m_ready), 32'(tv[i].mr));
      chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tv[i].we));
      chk($sformatf("v%0d rf_a3", i), 32'(rf_a3), 32'(tv[i].a3));
      chk($sformatf("v%0d rf_wd", i), rf_wd, tv[i].wd);
      chk($sformatf("v%0d pend_mask", i), pend_mask, tv[i].pm);
      tick();
    end
    // starvation: P hammers x3 while one M result for x8 waits
    drive(0, 1, 3, 32'h33, 1, 8, 32'h88);
    tick();
    for (int k = 0; k < SL; k++) begin
      drive(0, 1, 3, 32'h33, 0, 0, 0);
      chk($sformatf("starve p_ready%0d", k), 32'(p_ready), 1);
      tick();
    end
    drive(0, 1, 3, 32'h33, 0, 0, 0);
    chk("starve forced p_ready", 32'(p_ready), 0);
    tick();
    drive(0, 1, 3, 32'h33, 0, 0, 0);
    chk("starve m write we", 32'(rf_we), 1);
    chk("starve m write a3", 32'(rf_a3), 8);
    chk("starve m write wd", rf_wd, 32'h88);
    chk("starve p resumes ready", 32'(p_ready), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("starve p resumes a3", 32'(rf_a3), 3);
    tick();
    // reset with two M results buffered behind a busy P
    drive(0, 1, 3, 32'h1, 1, 20, 32'h77);
    tick();
    drive(0, 1, 3, 32'h2, 1, 21, 32'h78);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("midrst pend before", pend_mask, (32'(1) << 3) | (32'(1) << 20) | (32'(1) << 21));
    chk("midrst p_ready", 32'(p_ready), 0);
    chk("midrst m_ready", 32'(m_ready), 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("midrst we%0d", k), 32'(rf_we), 0);
      chk($sformatf("midrst pend%0d", k), pend_mask, 0);
      chk($sformatf("midrst m_ready%0d", k), 32'(m_ready), 1);
      if (k == 0) begin
        chk("midrst a3", 32'(rf_a3), 0);
        chk("midrst wd", rf_wd, 0);
      end
      tick();
    end
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(63) == 0, $urandom_range(9) < 7,
            5'($urandom_range(3) == 0 ? 0 : $urandom_range(31)), $urandom,
            $urandom_range(1) == 1, 5'($urandom_range(7) == 0 ? 0 : $urandom_range(31)), $urandom);
      check_model(c);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
